// File: rtl/uctl_memresp.sv
// uctl_memresp: responder end of the uctl memory request interface.
// Maps single-word read/write requests onto a single-port synchronous
// local-buffer SRAM with a fixed read latency. Out-of-range accesses are
// still acknowledged (reads return zero) and raise a sticky error flag.
module uctl_memresp #(
  parameter int          MEM_AW    = 12,
  parameter int          RD_LAT    = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              core_clk,
  input  logic              uctl_rst,
  input  logic              mem_req,
  input  logic              mem_wrRd,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wrData,
  output logic              mem_ack,
  output logic              mem_rdVal,
  output logic [31:0]       mem_rdData,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [MEM_AW-1:0] sram_addr,
  output logic [31:0]       sram_wrData,
  input  logic [31:0]       sram_rdData,
  input  logic              err_clr,
  output logic              err_addr
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  // Counter load value; RD_LAT is limited to 1..4 so three bits suffice.
  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              oor_q, oor_d;          // pending read was out of range
  logic              mem_ack_q, mem_ack_d;
  logic              mem_rdval_q, mem_rdval_d;
  logic [31:0]       mem_rddata_q, mem_rddata_d;
  logic              sram_ce_q, sram_ce_d;
  logic              sram_we_q, sram_we_d;
  logic [MEM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [31:0]       sram_wrdata_q, sram_wrdata_d;
  logic              err_addr_q, err_addr_d;

  logic [31:0]       off;
  logic              in_range;
  logic [MEM_AW-1:0] word_addr;
  logic              accept;

  // Address decode: offset from the window base, range test and word index.
  always_comb begin
    off       = mem_addr - BASE_ADDR;
    word_addr = off[MEM_AW+1:2];
    if ((mem_addr >= BASE_ADDR) && ((off >> (MEM_AW + 2)) == 32'h0000_0000)) begin
      in_range = 1'b1;
    end else begin
      in_range = 1'b0;
    end
  end

  // A request is taken only in IDLE and never in the cycle its ack is shown,
  // because the initiator still holds mem_req high during that cycle.
  assign accept = (state_q == IDLE) && mem_req && !mem_ack_q;

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    oor_d         = oor_q;
    mem_ack_d     = 1'b0;
    mem_rdval_d   = 1'b0;
    mem_rddata_d  = mem_rddata_q;
    sram_ce_d     = 1'b0;
    sram_we_d     = 1'b0;
    sram_addr_d   = sram_addr_q;
    sram_wrdata_d = sram_wrdata_q;

    // Sticky error: a new out-of-range acceptance beats a simultaneous clear.
    if (accept && !in_range) begin
      err_addr_d = 1'b1;
    end else if (err_clr) begin
      err_addr_d = 1'b0;
    end else begin
      err_addr_d = err_addr_q;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          mem_ack_d = 1'b1;
          if (in_range) begin
            sram_ce_d   = 1'b1;
            sram_we_d   = mem_wrRd;
            sram_addr_d = word_addr;
          end else begin
            sram_ce_d   = 1'b0;
          end
          if (mem_wrRd) begin
            if (in_range) begin
              sram_wrdata_d = mem_wrData;
            end else begin
              sram_wrdata_d = sram_wrdata_q;
            end
          end else begin
            // Out-of-range reads still wait the full latency, then return zero.
            state_d = RD_WAIT;
            cnt_d   = LAT_LOAD;
            oor_d   = !in_range;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (cnt_q <= 3'd1) begin
          mem_rdval_d = 1'b1;
          if (oor_q) begin
            mem_rddata_d = 32'h0000_0000;
          end else begin
            mem_rddata_d = sram_rdData;
          end
          cnt_d   = 3'd0;
          oor_d   = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
        oor_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any read in flight.
  always_ff @(posedge core_clk or posedge uctl_rst) begin
    if (uctl_rst) begin
      state_q       <= IDLE;
      cnt_q         <= 3'd0;
      oor_q         <= 1'b0;
      mem_ack_q     <= 1'b0;
      mem_rdval_q   <= 1'b0;
      mem_rddata_q  <= 32'h0000_0000;
      sram_ce_q     <= 1'b0;
      sram_we_q     <= 1'b0;
      sram_addr_q   <= '0;
      sram_wrdata_q <= 32'h0000_0000;
      err_addr_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      oor_q         <= oor_d;
      mem_ack_q     <= mem_ack_d;
      mem_rdval_q   <= mem_rdval_d;
      mem_rddata_q  <= mem_rddata_d;
      sram_ce_q     <= sram_ce_d;
      sram_we_q     <= sram_we_d;
      sram_addr_q   <= sram_addr_d;
      sram_wrdata_q <= sram_wrdata_d;
      err_addr_q    <= err_addr_d;
    end
  end

  assign mem_ack     = mem_ack_q;
  assign mem_rdVal   = mem_rdval_q;
  assign mem_rdData  = mem_rddata_q;
  assign sram_ce     = sram_ce_q;
  assign sram_we     = sram_we_q;
  assign sram_addr   = sram_addr_q;
  assign sram_wrData = sram_wrdata_q;
  assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_uctl_memresp.sv
// tb_uctl_memresp: five responders run side by side on shared request
// stimulus. Lane 0 has RD_LAT=2 and BASE_ADDR=0; lanes 1..4 have RD_LAT=1..4
// and BASE_ADDR=0x0002_0000 (lane address = relative address + base).
// A timeline reference model predicts each lane's outputs period by period.
module tb_uctl_memresp;

  localparam int NL = 5;
  localparam int AW = 12;
  localparam int NW = 4096;

  logic        core_clk   = 1'b0;
  logic        uctl_rst   = 1'b1;
  logic        mem_req    = 1'b0;
  logic        mem_wrRd   = 1'b0;
  logic        err_clr    = 1'b0;
  logic [31:0] addr_rel   = 32'h0;
  logic [31:0] mem_wrData = 32'h0;

  logic [31:0]   lane_addr [NL];
  logic          ack_w [NL];
  logic          rdv_w [NL];
  logic          ce_w  [NL];
  logic          we_w  [NL];
  logic          err_w [NL];
  logic [31:0]   rdd_w [NL];
  logic [31:0]   swd_w [NL];
  logic [31:0]   srd_w [NL];
  logic [AW-1:0] sa_w  [NL];

  always #5 core_clk = ~core_clk;

  for (genvar g = 0; g < NL; g++) begin : g_lane
    assign lane_addr[g] = addr_rel + ((g == 0) ? 32'h0 : 32'h0002_0000);
    uctl_memresp #(
      .MEM_AW(AW),
      .RD_LAT((g == 0) ? 2 : g),
      .BASE_ADDR((g == 0) ? 32'h0 : 32'h0002_0000)
    ) u_dut (
      .core_clk(core_clk), .uctl_rst(uctl_rst),
      .mem_req(mem_req), .mem_wrRd(mem_wrRd), .mem_addr(lane_addr[g]),
      .mem_wrData(mem_wrData), .mem_ack(ack_w[g]), .mem_rdVal(rdv_w[g]),
      .mem_rdData(rdd_w[g]), .sram_ce(ce_w[g]), .sram_we(we_w[g]),
      .sram_addr(sa_w[g]), .sram_wrData(swd_w[g]), .sram_rdData(srd_w[g]),
      .err_clr(err_clr), .err_addr(err_w[g])
    );
  end

  function automatic int lane_lat(int l);
    return (l == 0) ? 2 : l;
  endfunction

  function automatic logic [31:0] lane_base(int l);
    return (l == 0) ? 32'h0 : 32'h0002_0000;
  endfunction

  function automatic logic [31:0] init_word(int l, int i);
    return 32'h1357_9BDF ^ (32'(i) * 32'h0001_0003) ^ (32'(l) << 28);
  endfunction

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model (timeline of expected events) ----------
  int          t = 0;
  int          next_ok [NL];
  int          ack_at  [NL];
  int          ce_at   [NL];
  int          rdv_at  [NL];
  logic        exp_we  [NL];
  logic [31:0] rdv_data  [NL];
  logic [31:0] rdata_exp [NL];
  logic [31:0] swd_exp   [NL];
  logic [31:0] sa_exp    [NL];
  logic        err_exp   [NL];
  logic [31:0] ref_mem  [NL][NW];
  logic [31:0] sram_mem [NL][NW];
  logic        pend_v [NL];
  int          pend_c [NL];
  logic [AW-1:0] pend_a [NL];

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      next_ok[l] = 0; ack_at[l] = -1; ce_at[l] = -1; rdv_at[l] = -1;
      exp_we[l] = 1'b0; rdv_data[l] = 32'h0; rdata_exp[l] = 32'h0;
      swd_exp[l] = 32'h0; sa_exp[l] = 32'h0; err_exp[l] = 1'b0;
      pend_v[l] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [31:0] a, off, widx;
    logic        inr;
    t++;
    if (uctl_rst) return;
    for (int l = 0; l < NL; l++) begin
      if (t == rdv_at[l]) rdata_exp[l] = rdv_data[l];
      if (mem_req && t >= next_ok[l]) begin
        a    = lane_addr[l];
        off  = a - lane_base(l);
        widx = off >> 2;
        inr  = (a >= lane_base(l)) && (widx < 32'(NW));
        ack_at[l] = t;
        if (inr) begin
          ce_at[l]  = t;
          exp_we[l] = mem_wrRd;
          sa_exp[l] = widx;
        end
        if (mem_wrRd) begin
          next_ok[l] = t + 2;
          if (inr) begin
            swd_exp[l] = mem_wrData;
            ref_mem[l][widx] = mem_wrData;
          end
        end else begin
          next_ok[l]  = t + lane_lat(l) + 1;
          rdv_at[l]   = t + lane_lat(l);
          rdv_data[l] = inr ? ref_mem[l][widx] : 32'h0;
        end
        if (!inr) err_exp[l] = 1'b1;
        else if (err_clr) err_exp[l] = 1'b0;
      end else if (err_clr) begin
        err_exp[l] = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge core_clk);
    model_step();
  end

  // SRAM models: data is valid only in the period RD_LAT-1 after the ce period.
  initial forever begin
    @(negedge core_clk);
    for (int l = 0; l < NL; l++) begin
      if (uctl_rst) begin
        pend_v[l] = 1'b0;
      end else begin
        if (ce_w[l] && we_w[l]) sram_mem[l][sa_w[l]] = swd_w[l];
        if (ce_w[l] && !we_w[l]) begin
          pend_v[l] = 1'b1; pend_c[l] = lane_lat(l) - 1; pend_a[l] = sa_w[l];
        end else if (pend_v[l]) begin
          pend_c[l]--;
        end
      end
      if (pend_v[l] && pend_c[l] == 0) begin
        srd_w[l] = sram_mem[l][pend_a[l]];
        pend_v[l] = 1'b0;
      end else begin
        srd_w[l] = $urandom;
      end
    end
  end

  // Per-period comparison of every lane against the model.
  initial forever begin
    @(negedge core_clk);
    for (int l = 0; l < NL; l++) begin
      check($sformatf("ack%0d", l),   32'(ack_w[l]), 32'(ack_at[l] == t));
      check($sformatf("rdval%0d", l), 32'(rdv_w[l]), 32'(rdv_at[l] == t));
      check($sformatf("ce%0d", l),    32'(ce_w[l]),  32'(ce_at[l] == t));
      if (ce_at[l] == t) check($sformatf("we%0d", l), 32'(we_w[l]), 32'(exp_we[l]));
      check($sformatf("saddr%0d", l), 32'(sa_w[l]),  sa_exp[l]);
      check($sformatf("swdata%0d", l), swd_w[l],     swd_exp[l]);
      check($sformatf("rdata%0d", l),  rdd_w[l],     rdata_exp[l]);
      check($sformatf("err%0d", l),   32'(err_w[l]), 32'(err_exp[l]));
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic req_start(logic wr, logic [31:0] a, logic [31:0] d);
    mem_req = 1'b1; mem_wrRd = wr; addr_rel = a; mem_wrData = d;
  endtask

  task automatic check_reset(int l);
    check("rst_ack",   32'(ack_w[l]), 32'h0);
    check("rst_rdval", 32'(rdv_w[l]), 32'h0);
    check("rst_rdata", rdd_w[l],      32'h0);
    check("rst_ce",    32'(ce_w[l]),  32'h0);
    check("rst_we",    32'(we_w[l]),  32'h0);
    check("rst_saddr", 32'(sa_w[l]),  32'h0);
    check("rst_swdat", swd_w[l],      32'h0);
    check("rst_err",   32'(err_w[l]), 32'h0);
  endtask

  int unsigned cat, hold, gap;
  logic [31:0] ra;

  initial begin
    for (int l = 0; l < NL; l++)
      for (int i = 0; i < NW; i++) begin
        ref_mem[l][i]  = init_word(l, i);
        sram_mem[l][i] = init_word(l, i);
      end
    model_reset();
    repeat (3) @(negedge core_clk);
    for (int l = 0; l < NL; l++) check_reset(l);
    #2 uctl_rst = 1'b0;

    // Write 0xA5A5_0001 to byte 0x10.
    @(negedge core_clk); req_start(1'b1, 32'h10, 32'hA5A5_0001);
    @(negedge core_clk);
    check("wr_ack", 32'(ack_w[0]), 32'h1);
    check("wr_ce",  32'(ce_w[0]),  32'h1);
    check("wr_we",  32'(we_w[0]),  32'h1);
    check("wr_sa",  32'(sa_w[0]),  32'h4);
    check("wr_wd",  swd_w[0],      32'hA5A5_0001);
    check("wr_err", 32'(err_w[0]), 32'h0);
    @(negedge core_clk); mem_req = 1'b0;
    repeat (6) @(negedge core_clk);

    // Read it back; request held into the wait period.
    req_start(1'b0, 32'h10, 32'h0);
    for (int k = 0; k <= 4; k++) begin
      @(negedge core_clk);
      check("rd_ack", 32'(ack_w[0]), 32'(k == 0));
      check("rd_val", 32'(rdv_w[0]), 32'(k == 2));
      if (k == 2) begin
        check("rd_data", rdd_w[0], 32'hA5A5_0001);
        mem_req = 1'b0;
      end
    end
    repeat (6) @(negedge core_clk);

    // Back-to-back writes with mem_req held continuously.
    req_start(1'b1, 32'h0, 32'h1111_0000);
    for (int k = 0; k <= 3; k++) begin
      @(negedge core_clk);
      check("b2b_ack", 32'(ack_w[0]), 32'(k == 0 || k == 2));
      if (k == 0) begin
        check("b2b_sa0", 32'(sa_w[0]), 32'h0);
        addr_rel = 32'h4; mem_wrData = 32'h2222_0004;
      end
      if (k == 2) check("b2b_sa1", 32'(sa_w[0]), 32'h1);
      if (k == 3) mem_req = 1'b0;
    end
    repeat (6) @(negedge core_clk);

    // Read one word past the end.
    req_start(1'b0, 32'h4000, 32'h0);
    for (int k = 0; k <= 4; k++) begin
      @(negedge core_clk);
      check("oor_ce",  32'(ce_w[0]),  32'h0);
      check("oor_val", 32'(rdv_w[0]), 32'(k == 2));
      check("oor_err", 32'(err_w[0]), 32'h1);
      if (k == 2) check("oor_data", rdd_w[0], 32'h0);
      if (k == 1) mem_req = 1'b0;
    end
    err_clr = 1'b1;
    @(negedge core_clk); err_clr = 1'b0;
    check("clr_err", 32'(err_w[0]), 32'h0);
    // Out-of-range write, then another with err_clr in its acceptance cycle.
    req_start(1'b1, 32'h4000, 32'h5);
    @(negedge core_clk); @(negedge core_clk); mem_req = 1'b0;
    @(negedge core_clk);
    req_start(1'b1, 32'h4000, 32'h6); err_clr = 1'b1;
    @(negedge core_clk);
    check("setwin_err", 32'(err_w[0]), 32'h1);
    @(negedge core_clk);
    check("clr2_err", 32'(err_w[0]), 32'h0);
    err_clr = 1'b0; mem_req = 1'b0;
    repeat (6) @(negedge core_clk);

    // Reset in the second period of a RD_LAT=4 read (lane 4).
    req_start(1'b0, 32'h10, 32'h0);
    @(negedge core_clk); @(negedge core_clk); mem_req = 1'b0;
    #2 uctl_rst = 1'b1; model_reset();
    #1 check_reset(4);
    repeat (2) @(negedge core_clk);
    #2 uctl_rst = 1'b0;
    repeat (8) @(negedge core_clk);
    req_start(1'b0, 32'h10, 32'h0);
    for (int k = 0; k <= 5; k++) begin
      @(negedge core_clk);
      check("prst_ack", 32'(ack_w[4]), 32'(k == 0));
      check("prst_val", 32'(rdv_w[4]), 32'(k == 4));
      if (k == 4) check("prst_data", rdd_w[4], 32'hA5A5_0001);
      if (k == 1) mem_req = 1'b0;
    end
    repeat (4) @(negedge core_clk);

    // Latency sweep on lanes 1..4 (base 0x0002_0000), address 0x0002_0008.
    req_start(1'b0, 32'h8, 32'h0);
    for (int k = 0; k <= 5; k++) begin
      @(negedge core_clk);
      for (int l = 1; l < NL; l++) begin
        if (k == 0) check("swp_sa", 32'(sa_w[l]), 32'h2);
        check("swp_val", 32'(rdv_w[l]), 32'(k == lane_lat(l)));
        if (k == lane_lat(l)) check("swp_data", rdd_w[l], init_word(l, 2));
      end
      if (k == 1) mem_req = 1'b0;
    end
    // 0x0001_FFFC lies below the window.
    req_start(1'b0, 32'hFFFF_FFFC, 32'h0);
    @(negedge core_clk);
    for (int l = 1; l < NL; l++) begin
      check("below_ce",  32'(ce_w[l]),  32'h0);
      check("below_err", 32'(err_w[l]), 32'h1);
    end
    @(negedge core_clk); mem_req = 1'b0;
    repeat (6) @(negedge core_clk);

    // Randomized traffic.
    repeat (300) begin
      cat = $urandom_range(0, 5);
      case (cat)
        0, 1, 2: ra = ($urandom_range(0, NW - 1) << 2) | 32'($urandom_range(0, 3));
        3:       ra = 32'h3FF8 + 32'($urandom_range(0, 15));
        4:       ra = 32'hFFFF_FFFC - 32'($urandom_range(0, 7));
        default: ra = $urandom;
      endcase
      req_start(1'($urandom_range(0, 1)), ra, $urandom);
      hold = $urandom_range(1, 6);
      repeat (hold) begin
        err_clr = ($urandom_range(0, 7) == 0);
        @(negedge core_clk);
      end
      mem_req = 1'b0;
      gap = $urandom_range(0, 4);
      repeat (gap) begin
        err_clr = ($urandom_range(0, 7) == 0);
        @(negedge core_clk);
      end
    end
    err_clr = 1'b0;
    repeat (10) @(negedge core_clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
